// File: rtl/seq_detect_prog.sv
// ---------------------------------------------------------------------------
// seq_detect_prog
//
// Programmable serial bit-sequence detector. A pattern of 1..MAX_LEN bits is
// loaded at runtime and matched against a qualified serial bit stream, with
// either overlapping or non-overlapping match semantics. Every match produces
// a registered one-cycle pulse on seq_seen and, when the counter is built,
// bumps a saturating match counter.
//
// Build option:
//   SEQ_DETECT_COUNT_EN  defined   -> match counter built, drives match_count
//                        undefined -> no counter, match_count tied to 0,
//                                     count_clr ignored
//
// Parameters:
//   MAX_LEN  maximum pattern length in bits (>= 4)
//   CNT_W    match counter width
//   LEN_W    width of the length field (derived, do not override)
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   cfg_we       load pattern/length/overlap this cycle (in_valid ignored)
//   cfg_pattern  pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length; > MAX_LEN clamps, 0 never matches
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     inp_bit is sampled this cycle
//   inp_bit      serial data
//   count_clr    clear the match counter (wins over a same-cycle increment)
//   seq_seen     registered one-cycle match pulse
//   match_count  saturating match count
// ---------------------------------------------------------------------------
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               inp_bit,
    input  logic               count_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(4'b1011);
    localparam logic [LEN_W-1:0]   DEFAULT_LEN = LEN_W'(4);

    // Configuration registers
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    // Shift history and count of valid bits in it
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    // Next-sample values and match decision
    logic [MAX_LEN-1:0] h_next;
    logic [LEN_W-1:0]   f_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_clamped;
    logic               match;

    // The oldest history bit shifts out and is never compared.
    logic unused_hist_msb;
    assign unused_hist_msb = hist[MAX_LEN-1];

    // NOTE: every signal written here is given a default before any
    // conditional logic, so no path leaves a value held and no latch is built.
    always_comb begin
        h_next      = {hist[MAX_LEN-2:0], inp_bit};
        // Saturate explicitly rather than computing fill+1 first: when
        // MAX_LEN+1 is a power of two, fill+1 would wrap in LEN_W bits.
        f_next      = (fill == MAX_LEN_L) ? fill : fill + LEN_W'(1);
        len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;

        // Only the low len bits of history and pattern take part in a match.
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end

        match = in_valid && !cfg_we && (len != '0) && (f_next >= len) &&
                (((h_next ^ pat) & len_mask) == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat      <= DEFAULT_PAT;
            len      <= DEFAULT_LEN;
            ovl      <= 1'b1;
            hist     <= '0;
            fill     <= '0;
            seq_seen <= 1'b0;
        end else if (cfg_we) begin
            // A new configuration starts from an empty history.
            pat      <= cfg_pattern;
            len      <= len_clamped;
            ovl      <= cfg_overlap;
            hist     <= '0;
            fill     <= '0;
            seq_seen <= 1'b0;
        end else if (in_valid) begin
            hist     <= h_next;
            // Non-overlapping: empty the fill count so no bit of this match
            // can be counted towards the next one.
            fill     <= (match && !ovl) ? '0 : f_next;
            seq_seen <= match;
        end else begin
            seq_seen <= 1'b0;
        end
    end

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || count_clr) begin
            cnt <= '0;
        end else if (match && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_prog
//
// Directed self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
// Inputs change 1 time unit after a rising edge; outputs are read 1 time
// unit after the edge that registers them. Expected counter values follow
// whether SEQ_DETECT_COUNT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

`ifdef SEQ_DETECT_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               inp_bit;
    logic               count_clr;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;

    int checks   = 0;
    int failures = 0;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .inp_bit     (inp_bit),
        .count_clr   (count_clr),
        .seq_seen    (seq_seen),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no comparisons) ----------------

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One valid bit; returns seq_seen as registered by that edge.
    task automatic send(input logic b, output logic seen);
        in_valid = 1'b1;
        inp_bit  = b;
        tick();
        in_valid = 1'b0;
        seen     = seq_seen;
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                             input logic o);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic clear_count();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        do_reset();
        checks++;
        if (seq_seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_seq_seen got=%b exp=0", seq_seen);
        end
        checks++;
        if (match_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_match_count got=%0d exp=0", match_count);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001001;
        logic       seen;
        logic [CNT_W-1:0] exp_cnt;
        for (int i = 6; i >= 0; i--) begin
            send(bits[i], seen);
            checks++;
            if (seen !== exp[i]) begin
                failures++;
                $display("FAIL overlap_bit%0d got=%b exp=%b", 7 - i, seen, exp[i]);
            end
        end
        exp_cnt = CNT_ON ? 2'd2 : 2'd0;
        checks++;
        if (match_count !== exp_cnt) begin
            failures++;
            $display("FAIL overlap_count got=%0d exp=%0d", match_count, exp_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [10:0] bits = 11'b1011011_1011;
        logic [10:0] exp  = 11'b0001000_0001;
        logic        seen;
        logic [CNT_W-1:0] exp_cnt;
        clear_count();
        configure(8'b0000_1011, 4'd4, 1'b0);
        checks++;
        if (seq_seen !== 1'b0) begin
            failures++;
            $display("FAIL nonovl_cfg_seen got=%b exp=0", seq_seen);
        end
        for (int i = 10; i >= 0; i--) begin
            send(bits[i], seen);
            checks++;
            if (seen !== exp[i]) begin
                failures++;
                $display("FAIL nonovl_bit%0d got=%b exp=%b", 11 - i, seen, exp[i]);
            end
        end
        exp_cnt = CNT_ON ? 2'd2 : 2'd0;
        checks++;
        if (match_count !== exp_cnt) begin
            failures++;
            $display("FAIL nonovl_count got=%0d exp=%0d", match_count, exp_cnt);
        end
    endtask

    // Pattern 111: back-to-back pulses with overlap, a single one without.
    task automatic test_len3();
        logic [4:0] exp_ovl  = 5'b00111;
        logic [4:0] exp_novl = 5'b00100;
        logic       seen;
        configure(8'b0000_0111, 4'd3, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            send(1'b1, seen);
            checks++;
            if (seen !== exp_ovl[i]) begin
                failures++;
                $display("FAIL len3_ovl_bit%0d got=%b exp=%b", 5 - i, seen, exp_ovl[i]);
            end
        end
        configure(8'b0000_0111, 4'd3, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            send(1'b1, seen);
            checks++;
            if (seen !== exp_novl[i]) begin
                failures++;
                $display("FAIL len3_novl_bit%0d got=%b exp=%b", 5 - i, seen, exp_novl[i]);
            end
        end
    endtask

    // Default pattern with an idle cycle after every valid bit.
    task automatic test_idle_gaps();
        logic [3:0] bits = 4'b1011;
        logic [3:0] exp  = 4'b0001;
        logic       seen;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            send(bits[i], seen);
            checks++;
            if (seen !== exp[i]) begin
                failures++;
                $display("FAIL idle_bit%0d got=%b exp=%b", 4 - i, seen, exp[i]);
            end
            tick();
            checks++;
            if (seq_seen !== 1'b0) begin
                failures++;
                $display("FAIL idle_gap%0d got=%b exp=0", 4 - i, seq_seen);
            end
        end
    endtask

    // 1,0,1 then reset then 1 must not complete 1011; a fresh 1011 still does.
    task automatic test_reset_mid();
        logic [3:0] fresh = 4'b1011;
        logic [3:0] exp   = 4'b0001;
        logic       seen;
        send(1'b1, seen);
        send(1'b0, seen);
        send(1'b1, seen);
        do_reset();
        send(1'b1, seen);
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_span got=%b exp=0", seen);
        end
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            send(fresh[i], seen);
            checks++;
            if (seen !== exp[i]) begin
                failures++;
                $display("FAIL reset_mid_fresh_bit%0d got=%b exp=%b", 4 - i, seen, exp[i]);
            end
        end
    endtask

    // cfg_len=15 clamps to 8; cfg_len=0 never matches.
    task automatic test_len_bounds();
        logic [7:0] pat = 8'b1101_0010;
        logic [7:0] exp = 8'b0000_0001;
        logic       seen;
        configure(pat, 4'd15, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            send(pat[i], seen);
            checks++;
            if (seen !== exp[i]) begin
                failures++;
                $display("FAIL clamp_bit%0d got=%b exp=%b", 8 - i, seen, exp[i]);
            end
        end
        configure(8'b0000_0000, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, seen);
            checks++;
            if (seen !== 1'b0) begin
                failures++;
                $display("FAIL len0_bit%0d got=%b exp=0", i + 1, seen);
            end
        end
    endtask

    task automatic test_counter();
        logic seen;
        logic [CNT_W-1:0] exp_cnt;
        clear_count();
        configure(8'b0000_0111, 4'd3, 1'b1);
        // Seven 1s: matches after bits 3..7 -> five matches, saturates at 3.
        for (int i = 0; i < 7; i++) send(1'b1, seen);
        exp_cnt = CNT_ON ? 2'd3 : 2'd0;
        checks++;
        if (match_count !== exp_cnt) begin
            failures++;
            $display("FAIL count_saturate got=%0d exp=%0d", match_count, exp_cnt);
        end
        // Clear coincides with a match: clear wins, pulse still fires.
        count_clr = 1'b1;
        send(1'b1, seen);
        count_clr = 1'b0;
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL count_clr_pulse got=%b exp=1", seen);
        end
        checks++;
        if (match_count !== 2'd0) begin
            failures++;
            $display("FAIL count_clr_priority got=%0d exp=0", match_count);
        end
        send(1'b1, seen);
        exp_cnt = CNT_ON ? 2'd1 : 2'd0;
        checks++;
        if (match_count !== exp_cnt) begin
            failures++;
            $display("FAIL count_after_clr got=%0d exp=%0d", match_count, exp_cnt);
        end
    endtask

    // cfg_we right after a match: pending pulse stays visible, history is
    // cleared, a valid bit in the cfg cycle is dropped, counter untouched.
    task automatic test_cfg_after_match();
        logic seen;
        logic [CNT_W-1:0] cnt_before;
        configure(8'b0000_0111, 4'd3, 1'b1);
        clear_count();
        send(1'b1, seen);
        send(1'b1, seen);
        send(1'b1, seen);
        cnt_before = CNT_ON ? 2'd1 : 2'd0;
        cfg_we      = 1'b1;
        cfg_pattern = 8'b0000_0111;
        cfg_len     = 4'd3;
        cfg_overlap = 1'b1;
        in_valid    = 1'b1;
        inp_bit     = 1'b1;
        #2;
        checks++;
        if (seq_seen !== 1'b1) begin
            failures++;
            $display("FAIL cfg_pending_pulse got=%b exp=1", seq_seen);
        end
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (seq_seen !== 1'b0) begin
            failures++;
            $display("FAIL cfg_cycle_seen got=%b exp=0", seq_seen);
        end
        checks++;
        if (match_count !== cnt_before) begin
            failures++;
            $display("FAIL cfg_keeps_count got=%0d exp=%0d", match_count, cnt_before);
        end
        send(1'b1, seen);
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL cfg_hist_clear1 got=%b exp=0", seen);
        end
        send(1'b1, seen);
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL cfg_hist_clear2 got=%b exp=0", seen);
        end
        send(1'b1, seen);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL cfg_new_match got=%b exp=1", seen);
        end
    endtask

    initial begin
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        inp_bit     = 1'b0;
        count_clr   = 1'b0;
        tick();

        test_reset();
        test_overlap();
        test_non_overlap();
        test_len3();
        test_idle_gaps();
        test_reset_mid();
        test_len_bounds();
        test_counter();
        test_cfg_after_match();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-sequence detector, the parametrised successor to the fixed 1011 detector. It matches a runtime-loaded pattern of 1..MAX_LEN bits against a qualified serial bit stream, in overlapping or non-overlapping mode. Each match produces a registered one-cycle pulse and can optionally update a saturating match counter. It sits on the serial input path beside the fixed detectors and is configured by the local control block.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits; must be ≥ 4.
- CNT_W, 8: match counter width.
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  load configuration this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- in_valid  in  1  inp_bit is sampled this cycle.
- inp_bit  in  1  serial data.
- count_clr  in  1  clear the match counter.
- seq_seen  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating match count.

## Operation
State:
- hist[MAX_LEN-1:0]: shift history.
- fill[LEN_W-1:0]: valid bits in history, saturating at MAX_LEN.
- pat, len, ovl: configuration registers.
- cnt: match counter.

Reset:
- pat = 4'b1011 zero-extended, len = 4, ovl = 1.
- hist = 0, fill = 0, seq_seen = 0, match_count = 0.

Configuration load (cfg_we=1):
- Latch pattern, length and overlap mode.
- Clear hist and fill; drive seq_seen = 0.
- in_valid is ignored that cycle.
- Length rules: cfg_len > MAX_LEN is clamped to MAX_LEN. cfg_len = 0 is stored as 0 and never matches.

Sample (cfg_we=0, in_valid=1):
- h' = {hist[MAX_LEN-2:0], inp_bit}.
- f' = min(fill+1, MAX_LEN).
- Match when len ≠ 0, f' ≥ len, and h'[len-1:0] == pat[len-1:0].
- On a match, seq_seen is set to 1 at this edge.
- If ovl=0 and a match occurs, fill is set to 0 instead of f', so no bit contributes to two matches. hist still loads h'.
- If ovl=1, fill = f'.

Idle (in_valid=0):
- hist and fill hold; seq_seen = 0.

Counter (when compiled in):
- count_clr=1 sets cnt = 0 and takes priority over an increment in the same cycle.
- Otherwise cnt increments at each match edge, saturating at 2^CNT_W-1.
- cfg_we does not affect cnt.

## Timing
- seq_seen is high exactly during the cycle after the edge that samples the final pattern bit. This is the same 1-cycle latency as the fixed detectors.
- Back-to-back overlapping matches give seq_seen high on consecutive cycles.
- match_count updates at the same edge that sets seq_seen.
- The new configuration applies to the first in_valid sample after the cfg_we cycle.
- Reset asserted mid-sequence discards all history; no match can span a reset.
- cfg_we asserted in the cycle after a match does not suppress that pending seq_seen pulse, which is already registered.

## Configuration
- SEQ_DETECT_COUNT_EN defined: the cnt register, the count_clr logic and the saturation logic are built; match_count is driven by cnt.
- SEQ_DETECT_COUNT_EN undefined: no counter logic is built; match_count is tied to 0 and count_clr is ignored. All other behaviour is identical.

## Test plan
- Reset defaults, overlap mode, stream 1,0,1,1,0,1,1 -> seq_seen high in the cycles after bits 4 and 7; match_count = 2.
- cfg_overlap=0, pattern 1011, len 4, stream 1,0,1,1,0,1,1 -> single pulse after bit 4. Then appending 1,0,1,1 -> second pulse after bit 11.
- Pattern 3'b111, len 3: overlap mode on five 1s -> pulses after bits 3, 4, 5. Non-overlap mode on five 1s -> pulse after bit 3 only.
- Default pattern 1011 with in_valid low between every bit -> one pulse, one cycle wide, after the 4th valid bit; idle cycles produce no pulses.
- Stream 1,0,1, then reset, then 1 -> no pulse. Separately, cfg_len = 15 with MAX_LEN = 8 -> length clamped to 8; an 8-bit pattern matches after 8 bits.
- CNT_W=2 with SEQ_DETECT_COUNT_EN defined: 5 matches -> match_count = 3 (saturated). count_clr asserted together with a match -> match_count = 0. Without the macro, match_count stays 0 throughout.
